instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Instruction fetch controller sitting between the combinational, word-indexed instruction ROM and the core's decode stage.
- Owns the fetch PC and drives the ROM address; the ROM returns its word in the same cycle.
- Buffers fetched words in a small FIFO and presents them downstream with a valid/ready handshake.
- Handles branch redirects (flush and refetch) and stops fetching after the self-loop halt word (B #-1).

Parameters:
- RESET_PC, 0, word address fetched first after reset.
- DEPTH, 2, prefetch FIFO entries (power of two, >= 2).
- HALT_WORD, 32'hEAFFFFFF, encoding of B #-1 (AL, offset -1); stops fetching once captured.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  fetch enable; 0 freezes PC and stops pushes (FIFO still drains).
- rom_addr  output  32  word address to ROM; equals fetch_pc register.
- rom_data  input  32  ROM word for rom_addr, same cycle.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  word address of out_instr.
- redirect_valid  input  1  branch taken; flush and refetch.
- redirect_pc  input  32  absolute word address of branch target.
- halted  output  1  sticky: HALT_WORD captured, fetching stopped.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, FIFO empty (count=0, pointers 0), halted=0.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, rom_addr=RESET_PC.
- Outputs out_instr and out_pc are driven from FIFO storage at the read pointer. When empty they read 0 (gated).
- pop = out_valid & out_ready.
- push = fetch_en & ~halted & ~redirect_valid & (count<DEPTH | pop). Pushing into a full FIFO is allowed when a pop occurs the same cycle.
- On push:
  - Store {fetch_pc, rom_data}.
  - fetch_pc <= fetch_pc+1, 32-bit wrap 0xFFFFFFFF->0.
  - If rom_data==HALT_WORD, halted <= 1 and fetch_pc is not incremented.
- Count: +1 on push only, -1 on pop only, unchanged when both occur.
- Latency and throughput:
  - A word fetched in cycle N is visible at the head in cycle N+1 when the FIFO was empty.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Backpressure: while out_valid=1 & out_ready=0, out_instr and out_pc hold stable.
- Redirect (highest priority):
  - FIFO flushed (count=0, pointers reset), fetch_pc <= redirect_pc, halted <= 0, no push that cycle.
  - out_valid=0 in cycle N+1. The target word appears at the head in cycle N+2 (pushed in N+1).
  - A pop coinciding with the redirect still counts as a completed handshake: that instruction was consumed.
  - Back-to-back redirects: last one wins; each cycle's redirect_pc overwrites fetch_pc.
- Halt:
  - Once halted=1, no further pushes occur. Already-buffered words, including HALT_WORD, still drain normally.
  - halted clears only on redirect or reset. fetch_en has no effect on halted.
- fetch_en=0: fetch_pc and halted are held, no pushes, pops continue.
- Reset asserted mid-stream discards all buffered instructions immediately (asynchronous). Fetch restarts at RESET_PC on the first clock edge after rst_n rises.

Test Plan:
- Stream from reset: ROM word[i]=i+0x100, out_ready=1, fetch_en=1 -> from cycle 1 after reset release, out_pc=0,1,2,3… and out_instr=0x100,0x101…, one per cycle, no bubbles.
- Backpressure: hold out_ready=0 for 5 cycles at out_pc=3 -> out_instr/out_pc held at PC 3; count saturates at 2 with rom_addr frozen at 5; release -> PCs 3,4,5,6… with no loss or duplication.
- Redirect: redirect_valid for 1 cycle with redirect_pc=36 while the FIFO holds PCs 10,11 -> out_valid=0 next cycle, then out_pc=36,37…; PCs 10 and 11 never appear after the flush.
- Redirect plus handshake same cycle: out_valid=1, out_ready=1 at PC 20, redirect to 5 -> PC 20 counted as consumed; next valid output is PC 5.
- Halt: ROM word[46]=0xEAFFFFFF -> PC 46 delivered with out_instr=0xEAFFFFFF; halted=1; rom_addr stays 46; no further out_valid after drain; redirect to 0 clears halted and resumes at PC 0.
- Reset mid-operation: assert rst_n=0 with 2 words buffered -> out_valid=0 immediately; after release, first out_pc=RESET_PC (0).

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle: ROM address/data, decode handshake, branch redirect and halt status.
// The master modport is the fetch controller; the slave modport is the core/ROM side.
interface instr_fetch_ctrl_if;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    input  fetch_en, rom_data, out_ready, redirect_valid, redirect_pc,
    output rom_addr, out_valid, out_instr, out_pc, halted
  );

  modport slave (
    output fetch_en, rom_data, out_ready, redirect_valid, redirect_pc,
    input  rom_addr, out_valid, out_instr, out_pc, halted
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, prefetches ROM words into a small FIFO,
// handles branch redirects (flush + refetch) and stops after capturing the self-loop halt word.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] HALT_WORD = 32'hEAFFFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_ctrl_if.master  bus
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;
  logic          r_halted;

  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_halt_hit;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & bus.out_ready;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign w_push     = bus.fetch_en & ~r_halted & ~bus.redirect_valid & ((r_count < FULL) | w_pop);
  assign w_halt_hit = (bus.rom_data == HALT_WORD);

  assign bus.rom_addr  = r_fetch_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_instr = w_valid ? r_instr[r_rd_ptr] : 32'd0;
  assign bus.out_pc    = w_valid ? r_pc[r_rd_ptr]    : 32'd0;
  assign bus.halted    = r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_PC;
      r_halted   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything; a coinciding pop is simply absorbed by the flush.
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_fetch_pc <= bus.redirect_pc;
      r_halted   <= 1'b0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= bus.rom_data;
        r_pc[r_wr_ptr]    <= r_fetch_pc;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
        if (w_halt_hit) begin
          r_halted <= 1'b1;
        end else begin
          r_fetch_pc <= r_fetch_pc + 32'd1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: per-cycle vector table plus an in-order
// scoreboard of every accepted instruction.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] HALT     = 32'hEAFFFFFF;
  localparam logic [31:0] HALT_PC  = 32'd46;

  logic clk;
  logic rst_n;
  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(
    .RESET_PC  (32'd0),
    .DEPTH     (2),
    .HALT_WORD (HALT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_model(input logic [31:0] a);
    return (a == HALT_PC) ? HALT : a + 32'h100;
  endfunction

  always_comb bus.rom_data = rom_model(bus.rom_addr);

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        fe, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, einstr, erom;
    logic        ehalt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic fe, rdy, rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, erom);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = ev ? epc : 32'd0;
    v.einstr = ev ? epc + 32'h100 : 32'd0;
    v.erom = erom; v.ehalt = 1'b0;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    logic [31:0] pc;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %h expected no handshake", bus.out_pc);
      end else begin
        pc = exp_q.pop_front();
        check32("sb_pc", bus.out_pc, pc);
        check32("sb_instr", bus.out_instr, rom_model(pc));
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    sb_check();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    at_neg();
    at_pos();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    check32("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) exp_q.push_back(32'(p));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b0;
    bus.fetch_en       = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    // Stream, 5-cycle backpressure at PC 3, then redirect to 36 with PCs 10,11 buffered.
    vecs[0]  = mk(1, 1, 0, 0,  0, 0,  0);
    vecs[1]  = mk(1, 1, 0, 0,  1, 0,  1);
    vecs[2]  = mk(1, 1, 0, 0,  1, 1,  2);
    vecs[3]  = mk(1, 1, 0, 0,  1, 2,  3);
    vecs[4]  = mk(1, 0, 0, 0,  1, 3,  4);
    for (int i = 5; i <= 8; i++) vecs[i] = mk(1, 0, 0, 0, 1, 3, 5);
    vecs[9]  = mk(1, 1, 0, 0,  1, 3,  5);
    for (int i = 10; i <= 15; i++) vecs[i] = mk(1, 1, 0, 0, 1, 32'(i - 6), 32'(i - 4));
    vecs[16] = mk(1, 0, 1, 36, 1, 10, 12);
    vecs[17] = mk(1, 1, 0, 0,  0, 0,  36);
    vecs[18] = mk(1, 1, 0, 0,  1, 36, 37);
    vecs[19] = mk(1, 1, 0, 0,  1, 37, 38);

    at_pos();
    at_neg();
    check32("rst_valid", 32'(bus.out_valid), 32'd0);
    check32("rst_instr", bus.out_instr, 32'd0);
    check32("rst_pc", bus.out_pc, 32'd0);
    check32("rst_rom_addr", bus.rom_addr, 32'd0);
    check32("rst_halted", 32'(bus.halted), 32'd0);
    at_pos();
    rst_n = 1'b1;

    push_range(0, 9);
    push_range(36, 38);
    for (int i = 0; i < 20; i++) begin
      bus.fetch_en       = vecs[i].fe;
      bus.out_ready      = vecs[i].rdy;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      at_neg();
      check32($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      check32($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].epc);
      check32($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].einstr);
      check32($sformatf("vec%0d_rom_addr", i), bus.rom_addr, vecs[i].erom);
      check32($sformatf("vec%0d_halted", i), 32'(bus.halted), 32'(vecs[i].ehalt));
      at_pos();
    end
    bus.redirect_valid = 1'b0;

    // Redirect to 20 (PC 38 consumed), then redirect to 5 while PC 20 is handshaken.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd20;
    tick();
    bus.redirect_valid = 1'b0;
    at_neg();
    check32("redir20_bubble", 32'(bus.out_valid), 32'd0);
    check32("redir20_rom_addr", bus.rom_addr, 32'd20);
    at_pos();
    exp_q.push_back(32'd20);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd5;
    tick();
    bus.redirect_valid = 1'b0;
    check32("hs_redir_consumed", 32'(exp_q.size()), 32'd0);
    push_range(5, 46);
    at_neg();
    check32("redir5_bubble", 32'(bus.out_valid), 32'd0);
    check32("redir5_rom_addr", bus.rom_addr, 32'd5);
    at_pos();

    // Run into the halt word at PC 46.
    for (int i = 0; i < 100 && !bus.halted; i++) tick();
    check32("halt_set", 32'(bus.halted), 32'd1);
    check32("halt_rom_addr", bus.rom_addr, HALT_PC);
    drain(5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check32("halt_no_valid", 32'(bus.out_valid), 32'd0);
      check32("halt_rom_frozen", bus.rom_addr, HALT_PC);
      check32("halt_sticky", 32'(bus.halted), 32'd1);
    end

    // Redirect to 0 clears halt; then fetch_en=0 freezes the PC while the FIFO drains.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd0;
    tick();
    bus.redirect_valid = 1'b0;
    push_range(0, 2);
    at_neg();
    check32("resume_valid", 32'(bus.out_valid), 32'd0);
    check32("resume_halted", 32'(bus.halted), 32'd0);
    check32("resume_rom_addr", bus.rom_addr, 32'd0);
    at_pos();
    tick();
    tick();
    bus.fetch_en = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      at_neg();
      check32("fe0_valid", 32'(bus.out_valid), 32'd0);
      check32("fe0_rom_addr", bus.rom_addr, 32'd3);
      at_pos();
    end
    check32("fe0_drained", 32'(exp_q.size()), 32'd0);

    // Buffer two words, then reset asynchronously mid-cycle.
    bus.fetch_en  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    at_neg();
    check32("prerst_valid", 32'(bus.out_valid), 32'd1);
    check32("prerst_pc", bus.out_pc, 32'd3);
    check32("prerst_rom_addr", bus.rom_addr, 32'd5);
    at_pos();
    rst_n = 1'b0;
    #1;
    check32("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check32("async_rst_pc", bus.out_pc, 32'd0);
    check32("async_rst_instr", bus.out_instr, 32'd0);
    check32("async_rst_rom_addr", bus.rom_addr, 32'd0);
    tick();
    bus.out_ready = 1'b1;
    push_range(0, 2);
    rst_n = 1'b1;
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
